dsp_mac_engine: RTL and testbench

DSP_MAC_ENGINE -- requirements
Module: dsp_mac_engine

---
 rtl/dsp_mac_engine.sv | 167 ++++++++++++++++
 tb/tb_dsp_mac_engine.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_engine.sv
// Three-stage signed pre-add / multiply / accumulate engine that frames samples
// into bursts and hands each burst result off over a valid/ready port.
//
// state | meaning
// ACC   | accepting samples into the pipeline
// DRAIN | no new samples; waiting for the last one to retire from stage 3
// OUT   | holding P/CNT/OVF until the consumer takes them
module dsp_mac_engine #(
  parameter int AWIDTH   = 18,
  parameter int BWIDTH   = 18,
  parameter int PWIDTH   = 48,
  parameter int ACC_LEN  = 16,
  parameter int SATURATE = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [AWIDTH-1:0] A,
  input  logic signed [BWIDTH-1:0] B,
  input  logic signed [BWIDTH-1:0] D,
  input  logic        [3:0]        OPMODE,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PWIDTH-1:0] P,
  output logic        [15:0]       CNT,
  output logic                     OVF
);

  localparam int MW = AWIDTH + BWIDTH + 1;
  localparam logic [15:0] LP_LAST_CNT = 16'(ACC_LEN - 1);
  localparam bit LP_SAT = (SATURATE != 0);
  localparam logic signed [PWIDTH-1:0] LP_PMAX = {1'b0, {(PWIDTH-1){1'b1}}};
  localparam logic signed [PWIDTH-1:0] LP_PMIN = {1'b1, {(PWIDTH-1){1'b0}}};

  if (PWIDTH < AWIDTH + BWIDTH + 1) begin : g_pwidth_check
    $error("dsp_mac_engine: PWIDTH must be at least AWIDTH+BWIDTH+1");
  end
  if (ACC_LEN < 1 || ACC_LEN > 65535) begin : g_acc_len_check
    $error("dsp_mac_engine: ACC_LEN must lie in 1..65535");
  end

  typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_OUT} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_handoff;
  logic   w_cnt_at_max;

  logic                     r_s1_valid;
  logic signed [AWIDTH-1:0] r_a;
  logic signed [BWIDTH-1:0] r_b;
  logic signed [BWIDTH-1:0] r_d;
  logic        [2:0]        r_op;

  logic                     r_s2_valid;
  logic                     r_s2_sub;
  logic signed [MW-1:0]     r_m;

  logic signed [PWIDTH-1:0] r_acc;
  logic        [15:0]       r_cnt;
  logic                     r_ovf;

  logic signed [BWIDTH:0]   w_b_x;
  logic signed [BWIDTH:0]   w_d_x;
  logic signed [BWIDTH:0]   w_pre;
  logic signed [MW-1:0]     w_m;
  logic signed [PWIDTH:0]   w_sum;
  logic                     w_ovf;
  logic signed [PWIDTH-1:0] w_acc_nxt;

  assign w_cnt_at_max = (r_cnt == LP_LAST_CNT);
  assign w_accept     = in_valid && w_in_ready;
  assign w_handoff    = w_out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_ACC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_ACC: begin
        w_in_ready = 1'b1;
        if (in_valid && (OPMODE[3] || w_cnt_at_max)) w_state_nxt = ST_DRAIN;
      end
      // Once stage 1 is empty the last sample sits in stage 2 and retires this edge.
      ST_DRAIN: if (!r_s1_valid) w_state_nxt = ST_OUT;
      ST_OUT: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  assign w_b_x = (BWIDTH+1)'(r_b);
  assign w_d_x = (BWIDTH+1)'(r_d);

  always_comb begin
    w_pre = w_b_x;
    if (r_op[0]) w_pre = r_op[1] ? (w_d_x - w_b_x) : (w_d_x + w_b_x);
  end

  assign w_m = MW'(w_pre) * MW'(r_a);

  // One guard bit: overflow shows up as the top two bits of the sum disagreeing.
  assign w_sum = r_s2_sub ? ((PWIDTH+1)'(r_acc) - (PWIDTH+1)'(r_m))
                          : ((PWIDTH+1)'(r_acc) + (PWIDTH+1)'(r_m));
  assign w_ovf = w_sum[PWIDTH] ^ w_sum[PWIDTH-1];

  always_comb begin
    w_acc_nxt = w_sum[PWIDTH-1:0];
    if (w_ovf && LP_SAT) w_acc_nxt = w_sum[PWIDTH] ? LP_PMIN : LP_PMAX;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_d        <= '0;
      r_op       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sub   <= 1'b0;
      r_m        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_a  <= A;
        r_b  <= B;
        r_d  <= D;
        r_op <= OPMODE[2:0];
      end
      r_s2_valid <= r_s1_valid;
      r_s2_sub   <= r_op[2];
      r_m        <= w_m;
      if (w_handoff) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_accept) r_cnt <= r_cnt + 16'd1;
        if (r_s2_valid) begin
          r_acc <= w_acc_nxt;
          r_ovf <= r_ovf | w_ovf;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign P         = r_acc;
  assign CNT       = r_cnt;
  assign OVF       = r_ovf;

endmodule

// File: tb/tb_dsp_mac_engine.sv
// Bench for dsp_mac_engine: three instances (default, saturating 37-bit, wrapping
// 37-bit) driven from sample queues and checked against an arithmetic burst model.
module tb_dsp_mac_engine;

  typedef struct {
    logic signed [17:0] a;
    logic signed [17:0] b;
    logic signed [17:0] d;
    logic [3:0]         op;
    int                 gap;
    bit                 last;
  } smp_t;

  typedef struct {
    longint p;
    int     cnt;
    bit     ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               iv   [3];
  logic               ir   [3];
  logic signed [17:0] av   [3];
  logic signed [17:0] bv   [3];
  logic signed [17:0] dv   [3];
  logic [3:0]         opv  [3];
  logic               ov   [3];
  logic               ordy [3];
  logic [15:0]        cv   [3];
  logic               fv   [3];
  logic signed [47:0] p_a;
  logic signed [36:0] p_b;
  logic signed [36:0] p_c;
  logic signed [47:0] p_x  [3];

  assign p_x[0] = p_a;
  assign p_x[1] = 48'(p_b);
  assign p_x[2] = 48'(p_c);

  dsp_mac_engine #(.AWIDTH(18), .BWIDTH(18), .PWIDTH(48), .ACC_LEN(16), .SATURATE(0)) u_dut_a (
    .CLK(clk), .RST(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(av[0]), .B(bv[0]), .D(dv[0]),
    .OPMODE(opv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .P(p_a), .CNT(cv[0]), .OVF(fv[0]));

  dsp_mac_engine #(.AWIDTH(18), .BWIDTH(18), .PWIDTH(37), .ACC_LEN(4), .SATURATE(1)) u_dut_b (
    .CLK(clk), .RST(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(av[1]), .B(bv[1]), .D(dv[1]),
    .OPMODE(opv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .P(p_b), .CNT(cv[1]), .OVF(fv[1]));

  dsp_mac_engine #(.AWIDTH(18), .BWIDTH(18), .PWIDTH(37), .ACC_LEN(4), .SATURATE(0)) u_dut_c (
    .CLK(clk), .RST(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(av[2]), .B(bv[2]), .D(dv[2]),
    .OPMODE(opv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .P(p_c), .CNT(cv[2]), .OVF(fv[2]));

  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   hold_fix = -1;
  smp_t smp     [$];
  res_t exp_q   [$];
  int   end_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void add(int a, int b, int d, int op, int gap);
    smp_t s;
    s.a = 18'(a); s.b = 18'(b); s.d = 18'(d); s.op = 4'(op); s.gap = gap; s.last = 1'b0;
    smp.push_back(s);
  endfunction

  function automatic void add_exp(longint p, int cnt, bit ovf);
    res_t e;
    e.p = p; e.cnt = cnt; e.ovf = ovf;
    exp_q.push_back(e);
  endfunction

  // Burst model: plain 64-bit arithmetic, range-checked against a pw-bit signed accumulator.
  function automatic void model(int pw, bit sat, int acc_len);
    longint acc = 0, pre, m, hi, lo, span;
    int n = 0;
    bit o = 1'b0;
    span = longint'(1) <<< pw;
    hi = (longint'(1) <<< (pw - 1)) - 1;
    lo = -hi - 1;
    exp_q.delete();
    foreach (smp[i]) begin
      if (!smp[i].op[0])     pre = smp[i].b;
      else if (smp[i].op[1]) pre = smp[i].d - smp[i].b;
      else                   pre = smp[i].d + smp[i].b;
      m = pre * smp[i].a;
      acc = smp[i].op[2] ? acc - m : acc + m;
      if (acc > hi || acc < lo) begin
        o = 1'b1;
        if (sat) acc = (acc > hi) ? hi : lo;
        else begin
          acc = acc & (span - 1);
          if (acc > hi) acc = acc - span;
        end
      end
      n++;
      smp[i].last = smp[i].op[3] || (n == acc_len);
      if (smp[i].last) begin
        add_exp(acc, n, o);
        acc = 0; n = 0; o = 1'b0;
      end
    end
  endfunction

  task automatic gen_random(int n, int gapmax);
    smp.delete();
    for (int i = 0; i < n; i++) begin
      smp_t s;
      s.a = 18'($urandom); s.b = 18'($urandom); s.d = 18'($urandom);
      s.op = {($urandom_range(0, 5) == 0), 3'($urandom)};
      if (i == n - 1) s.op[3] = 1'b1;
      s.gap = $urandom_range(0, gapmax);
      s.last = 1'b0;
      smp.push_back(s);
    end
  endtask

  task automatic drive(int u);
    foreach (smp[i]) begin
      int t;
      repeat (smp[i].gap) begin iv[u] = 1'b0; @(negedge clk); end
      iv[u] = 1'b1; av[u] = smp[i].a; bv[u] = smp[i].b; dv[u] = smp[i].d; opv[u] = smp[i].op;
      t = 0;
      while (!ir[u] && t < 300) begin @(negedge clk); t++; end
      if (!ir[u]) begin
        total++; bad++;
        $display("FAIL in_ready_timeout u=%0d sample=%0d got in_ready=0 want 1 within 300 cycles", u, i);
        iv[u] = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (smp[i].last) end_cyc.push_back(cyc);
    end
    iv[u] = 1'b0;
  endtask

  task automatic consume(int u, int nres);
    for (int r = 0; r < nres; r++) begin
      res_t e;
      int t, h, ec;
      e = exp_q.pop_front();
      t = 0;
      while (!ov[u] && t < 400) begin ordy[u] = 1'($urandom_range(0, 1)); @(negedge clk); t++; end
      ordy[u] = 1'b0;
      total++;
      if (!ov[u]) begin
        bad++;
        $display("FAIL out_valid_timeout u=%0d result=%0d got out_valid=0 want 1", u, r);
        return;
      end
      ec = (end_cyc.size() > 0) ? end_cyc.pop_front() : -1000;
      total++;
      if (cyc !== ec + 2) begin bad++; $display("FAIL latency u=%0d got edge=%0d want edge=%0d", u, cyc, ec + 2); end
      h = (hold_fix >= 0) ? hold_fix : int'($urandom_range(0, 4));
      for (int j = 0; j <= h; j++) begin
        if (j > 0) @(negedge clk);
        total++;
        if (ov[u] !== 1'b1) begin bad++; $display("FAIL out_valid_hold u=%0d got=%0b want=1", u, ov[u]); end
        total++;
        if (ir[u] !== 1'b0) begin bad++; $display("FAIL in_ready_out u=%0d got=%0b want=0", u, ir[u]); end
        total++;
        if (p_x[u] !== 48'(e.p)) begin bad++; $display("FAIL p u=%0d r=%0d got=%0d want=%0d", u, r, p_x[u], e.p); end
        total++;
        if (cv[u] !== 16'(e.cnt)) begin bad++; $display("FAIL cnt u=%0d r=%0d got=%0d want=%0d", u, r, cv[u], e.cnt); end
        total++;
        if (fv[u] !== e.ovf) begin bad++; $display("FAIL ovf u=%0d r=%0d got=%0b want=%0b", u, r, fv[u], e.ovf); end
      end
      ordy[u] = 1'b1;
      @(negedge clk);
      ordy[u] = 1'b0;
      total++;
      if (ov[u] !== 1'b0) begin bad++; $display("FAIL handoff_valid u=%0d got=%0b want=0", u, ov[u]); end
      total++;
      if (ir[u] !== 1'b1) begin bad++; $display("FAIL handoff_ready u=%0d got=%0b want=1", u, ir[u]); end
      total++;
      if (p_x[u] !== 48'sd0 || cv[u] !== 16'd0 || fv[u] !== 1'b0) begin
        bad++; $display("FAIL handoff_clear u=%0d got p=%0d cnt=%0d ovf=%0b want 0/0/0", u, p_x[u], cv[u], fv[u]);
      end
    end
  endtask

  task automatic run(int u);
    int nres;
    nres = exp_q.size();
    end_cyc.delete();
    fork
      drive(u);
      consume(u, nres);
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (ov[u] !== 1'b0 || p_x[u] !== 48'sd0 || cv[u] !== 16'd0 || fv[u] !== 1'b0) begin
        bad++; $display("FAIL reset_out u=%0d got v=%0b p=%0d cnt=%0d ovf=%0b want 0", u, ov[u], p_x[u], cv[u], fv[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (ir[u] !== 1'b1) begin bad++; $display("FAIL reset_ready u=%0d got=%0b want=1", u, ir[u]); end
    end
  endtask

  task automatic test_basic();
    smp.delete();
    add(2, 3, 0, 0, 0); add(4, 5, 0, 0, 0); add(-1, 7, 0, 8, 0);
    model(48, 1'b0, 16);
    exp_q.delete(); add_exp(19, 3, 1'b0);
    run(0);
  endtask

  task automatic test_presub();
    smp.delete();
    add(-3, 4, 10, 4'b1011, 1);
    model(48, 1'b0, 16);
    exp_q.delete(); add_exp(-18, 1, 1'b0);
    run(0);
  endtask

  task automatic test_backpressure();
    smp.delete();
    add(3, -2, 0, 0, 0); add(7, 2, 1, 4'b1101, 2);
    model(48, 1'b0, 16);
    exp_q.delete(); add_exp(-27, 2, 1'b0);
    hold_fix = 5;
    run(0);
    hold_fix = -1;
  endtask

  task automatic test_cutoff();
    smp.delete();
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0);
    for (int i = 5; i <= 8; i++) add(i, 1, 0, 0, 0);
    model(37, 1'b1, 4);
    exp_q.delete(); add_exp(4, 4, 1'b0); add_exp(26, 4, 1'b0);
    hold_fix = 3;
    run(1);
    hold_fix = -1;
  endtask

  task automatic test_overflow();
    smp.delete();
    for (int i = 0; i < 4; i++) add(-131072, -131072, 0, 0, 0);
    model(37, 1'b1, 4);
    exp_q.delete(); add_exp(64'sd68719476735, 4, 1'b1);
    run(1);
    model(37, 1'b0, 4);
    exp_q.delete(); add_exp(-64'sd68719476736, 4, 1'b1);
    run(2);
  endtask

  task automatic test_random();
    gen_random(60, 2);
    model(48, 1'b0, 16);
    run(0);
    gen_random(40, 1);
    model(37, 1'b1, 4);
    run(1);
    model(37, 1'b0, 4);
    run(2);
  endtask

  task automatic test_reset_mid();
    iv[0] = 1'b1; av[0] = 18'sd3; bv[0] = 18'sd3; dv[0] = 18'sd0; opv[0] = 4'd0;
    @(posedge clk); @(negedge clk);
    av[0] = 18'sd4;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    total++;
    if (ov[0] !== 1'b0 || p_x[0] !== 48'sd0 || cv[0] !== 16'd0 || ir[0] !== 1'b1) begin
      bad++; $display("FAIL reset_mid u=0 got v=%0b p=%0d cnt=%0d rdy=%0b want 0/0/0/1", ov[0], p_x[0], cv[0], ir[0]);
    end
    repeat (3) @(negedge clk);
    total++;
    if (p_x[0] !== 48'sd0) begin bad++; $display("FAIL reset_inflight u=0 got p=%0d want=0", p_x[0]); end
    smp.delete();
    add(5, 5, 0, 8, 0);
    model(48, 1'b0, 16);
    exp_q.delete(); add_exp(25, 1, 1'b0);
    run(0);
  endtask

  task automatic test_reset_drain();
    iv[0] = 1'b1; av[0] = 18'sd7; bv[0] = 18'sd7; dv[0] = 18'sd0; opv[0] = 4'd8;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ov[0] !== 1'b0 || p_x[0] !== 48'sd0 || ir[0] !== 1'b1) begin
        bad++; $display("FAIL reset_drain u=0 cyc=%0d got v=%0b p=%0d rdy=%0b want 0/0/1", i, ov[0], p_x[0], ir[0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b0; av[u] = '0; bv[u] = '0; dv[u] = '0; opv[u] = '0;
    end
    test_reset();
    test_basic();
    test_presub();
    test_backpressure();
    test_cutoff();
    test_overflow();
    test_random();
    test_reset_mid();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion by t=%0t want completion", $time);
    $fatal(1, "bench timeout");
  end

endmodule
